// File: rtl/fibergyro_pkg.sv
// rtl/fibergyro_pkg.sv - shared state types, frame constants and TX frame byte helper
package fibergyro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_WAIT,
    ST_TX_STRB,
    ST_TX_HOLD,
    ST_TX_GUARD,
    ST_RX
  } seq_state_e;

  typedef enum logic [1:0] {
    RX_HUNT0,
    RX_HUNT1,
    RX_PAY,
    RX_CHK
  } rx_state_e;

  localparam logic [7:0] HDR0           = 8'hEB;
  localparam logic [7:0] HDR1           = 8'h90;
  localparam logic [7:0] CMD_CHK_SEED   = 8'h7B;
  localparam logic [1:0] STROBE_HOLDOFF = 2'd2;

  // Command frame is EB 90 cmd chk, with chk = seed + cmd (mod 256).
  function automatic logic [7:0] tx_frame_byte(input logic [1:0] idx, input logic [7:0] cmd);
    case (idx)
      2'd0:    return HDR0;
      2'd1:    return HDR1;
      2'd2:    return cmd;
      default: return cmd + CMD_CHK_SEED;
    endcase
  endfunction

endpackage

// File: rtl/fibergyro_rx_parser.sv
// rtl/fibergyro_rx_parser.sv - response header hunt, payload streaming and checksum check
module fibergyro_rx_parser
  import fibergyro_pkg::*;
#(
  parameter int RSP_LEN = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       byte_vld_i,
  input  logic [7:0] byte_i,
  output logic       chk_now_o,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic [3:0] rsp_idx_o,
  output logic       frame_done_o,
  output logic       frame_err_o
);

  localparam logic [3:0] IDX_LAST = 4'(RSP_LEN - 1);

  rx_state_e  state_q;
  logic [3:0] idx_q;
  logic [7:0] sum_q;
  logic       take;

  assign take      = byte_vld_i && !clear_i;
  assign chk_now_o = take && (state_q == RX_CHK);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RX_HUNT0;
      idx_q        <= 4'd0;
      sum_q        <= 8'd0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= 8'd0;
      rsp_idx_o    <= 4'd0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rsp_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      if (clear_i) begin
        state_q <= RX_HUNT0;
        idx_q   <= 4'd0;
        sum_q   <= 8'd0;
      end else if (take) begin
        case (state_q)
          RX_HUNT0: if (byte_i == HDR0) state_q <= RX_HUNT1;
          // A repeated sync byte may be the real start of the header.
          RX_HUNT1: begin
            if (byte_i == HDR1) begin
              state_q <= RX_PAY;
              idx_q   <= 4'd0;
              sum_q   <= 8'd0;
            end else if (byte_i != HDR0) begin
              state_q <= RX_HUNT0;
            end
          end
          RX_PAY: begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= byte_i;
            rsp_idx_o   <= idx_q;
            sum_q       <= sum_q + byte_i;
            if (idx_q == IDX_LAST) state_q <= RX_CHK;
            else idx_q <= idx_q + 4'd1;
          end
          default: begin
            frame_done_o <= 1'b1;
            frame_err_o  <= (byte_i != sum_q);
            state_q      <= RX_HUNT0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/fibergyro_poll_sequencer.sv
// rtl/fibergyro_poll_sequencer.sv - periodic gyro poll over CoreUART: command TX, response RX, timers
// Optional FIBGY_STATS_EN adds saturating good/error/timeout frame counters.
module fibergyro_poll_sequencer
  import fibergyro_pkg::*;
#(
  parameter int          POLL_PERIOD = 100000,
  parameter int          RSP_LEN     = 6,
  parameter int          TIMEOUT     = 50000,
  parameter int          TX_GUARD    = 1000,
  parameter logic [12:0] BAUD_VAL    = 13'd25
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        en,
  input  logic [7:0]  cmd_byte,
  input  logic        txrdy,
  input  logic        rxrdy,
  input  logic [7:0]  rx_data,
  output logic        wen_n,
  output logic        oen_n,
  output logic [7:0]  tx_data,
  output logic [12:0] baud_val,
  output logic        tx_en,
  output logic        rx_en,
  output logic [7:0]  rsp_data,
  output logic [3:0]  rsp_idx,
  output logic        rsp_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic        timeout,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] tmo_cnt
);

  localparam int PER_W = $clog2(POLL_PERIOD + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GRD_W = $clog2(TX_GUARD + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(POLL_PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(TX_GUARD - 1);

  seq_state_e       state_q;
  logic [PER_W-1:0] per_cnt_q;
  logic [TMO_W-1:0] tmo_tmr_q;
  logic [GRD_W-1:0] grd_cnt_q;
  logic [1:0]       byte_idx_q;
  logic [1:0]       hold_q;
  logic [7:0]       cmd_q;
  logic             wen_n_q;
  logic [7:0]       tx_data_q;
  logic             tx_en_q;
  logic             rx_en_q;
  logic             timeout_q;
  logic             oen_n_q;
  logic [1:0]       rd_hold_q;
  logic [7:0]       rx_byte_q;
  logic             rx_vld_q;
  logic             tick;
  logic             chk_now;
  logic             parser_clear;

  assign tick         = en && (per_cnt_q == PER_LAST);
  assign parser_clear = (state_q != ST_RX);

  assign wen_n    = wen_n_q;
  assign oen_n    = oen_n_q;
  assign tx_data  = tx_data_q;
  assign baud_val = BAUD_VAL;
  assign tx_en    = tx_en_q;
  assign rx_en    = rx_en_q;
  assign timeout  = timeout_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) per_cnt_q <= '0;
    else if (!en || tick) per_cnt_q <= '0;
    else per_cnt_q <= per_cnt_q + PER_W'(1);
  end

  // Reads run in every state so stray bytes never back up the UART receive FIFO.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      oen_n_q   <= 1'b1;
      rd_hold_q <= 2'd0;
      rx_byte_q <= 8'd0;
      rx_vld_q  <= 1'b0;
    end else begin
      rx_vld_q <= 1'b0;
      if (!oen_n_q) begin
        oen_n_q   <= 1'b1;
        rx_byte_q <= rx_data;
        rx_vld_q  <= 1'b1;
        rd_hold_q <= STROBE_HOLDOFF;
      end else if (rd_hold_q != 2'd0) begin
        rd_hold_q <= rd_hold_q - 2'd1;
      end else if (rxrdy) begin
        oen_n_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      tmo_tmr_q  <= '0;
      grd_cnt_q  <= '0;
      byte_idx_q <= 2'd0;
      hold_q     <= 2'd0;
      cmd_q      <= 8'd0;
      wen_n_q    <= 1'b1;
      tx_data_q  <= 8'd0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b1;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q    <= ST_TX_WAIT;
            cmd_q      <= cmd_byte;
            byte_idx_q <= 2'd0;
            tx_en_q    <= 1'b1;
            rx_en_q    <= 1'b0;
          end
        end
        ST_TX_WAIT: begin
          if (txrdy) begin
            wen_n_q   <= 1'b0;
            tx_data_q <= tx_frame_byte(byte_idx_q, cmd_q);
            state_q   <= ST_TX_STRB;
          end
        end
        ST_TX_STRB: begin
          wen_n_q <= 1'b1;
          hold_q  <= STROBE_HOLDOFF - 2'd1;
          state_q <= ST_TX_HOLD;
        end
        ST_TX_HOLD: begin
          if (hold_q != 2'd0) begin
            hold_q <= hold_q - 2'd1;
          end else if (byte_idx_q == 2'd3) begin
            grd_cnt_q <= '0;
            state_q   <= ST_TX_GUARD;
          end else begin
            byte_idx_q <= byte_idx_q + 2'd1;
            state_q    <= ST_TX_WAIT;
          end
        end
        // Guard time restarts whenever txrdy drops, so it counts from the final rise.
        ST_TX_GUARD: begin
          if (!txrdy) begin
            grd_cnt_q <= '0;
          end else if (grd_cnt_q == GRD_LAST) begin
            tx_en_q   <= 1'b0;
            rx_en_q   <= 1'b1;
            tmo_tmr_q <= '0;
            state_q   <= ST_RX;
          end else begin
            grd_cnt_q <= grd_cnt_q + GRD_W'(1);
          end
        end
        ST_RX: begin
          if (chk_now) begin
            state_q <= ST_IDLE;
          end else if (tmo_tmr_q == TMO_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            tmo_tmr_q <= tmo_tmr_q + TMO_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fibergyro_rx_parser #(
    .RSP_LEN(RSP_LEN)
  ) u_rx_parser (
    .clk_i       (CLK),
    .rst_ni      (RESET),
    .clear_i     (parser_clear),
    .byte_vld_i  (rx_vld_q),
    .byte_i      (rx_byte_q),
    .chk_now_o   (chk_now),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_idx_o   (rsp_idx),
    .frame_done_o(frame_done),
    .frame_err_o (frame_err)
  );

`ifdef FIBGY_STATS_EN
  logic [15:0] good_q;
  logic [15:0] err_q;
  logic [15:0] tmo_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      good_q <= 16'd0;
      err_q  <= 16'd0;
      tmo_q  <= 16'd0;
    end else begin
      if (frame_done && !frame_err && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      if (frame_done && frame_err && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      if (timeout && tmo_q != 16'hFFFF) tmo_q <= tmo_q + 16'd1;
    end
  end

  assign good_cnt = good_q;
  assign err_cnt  = err_q;
  assign tmo_cnt  = tmo_q;
`else
  assign good_cnt = 16'd0;
  assign err_cnt  = 16'd0;
  assign tmo_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_fibergyro_poll_sequencer.sv
// tb/tb_fibergyro_poll_sequencer.sv - directed bench: command TX, response parsing, timeout, resync, reset
module tb_fibergyro_poll_sequencer;

  localparam int POLL_PERIOD = 400;
  localparam int RSP_LEN     = 6;
  localparam int TIMEOUT     = 300;
  localparam int TX_GUARD    = 20;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        en;
  logic [7:0]  cmd_byte;
  logic        txrdy;
  logic        rxrdy;
  logic [7:0]  rx_data;
  logic        wen_n, oen_n, tx_en, rx_en, rsp_valid, frame_done, frame_err, timeout;
  logic [7:0]  tx_data, rsp_data;
  logic [12:0] baud_val;
  logic [3:0]  rsp_idx;
  logic [15:0] good_cnt, err_cnt, tmo_cnt;

  int errors = 0;
  int checks = 0;

  int          cyc = 0;
  int          busy = 0;
  bit          wen_seen = 0;
  int          rise_cyc = 0;
  int          fall_cyc = 0;
  int          tmo_cyc = 0;
  int          bad_strobe = 0;
  int          tx_n = 0;
  logic [7:0]  tx_b [8];
  int          rsp_n = 0;
  logic [7:0]  rsp_d [16];
  logic [3:0]  rsp_i [16];
  int          done_n = 0;
  logic        last_err = 1'b0;
  int          tmo_n = 0;
  int          txen_rise_n = 0;
  logic        txen_prev = 1'b0;
  logic [7:0]  frm [16];

  fibergyro_poll_sequencer #(
    .POLL_PERIOD(POLL_PERIOD),
    .RSP_LEN    (RSP_LEN),
    .TIMEOUT    (TIMEOUT),
    .TX_GUARD   (TX_GUARD),
    .BAUD_VAL   (13'd25)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .en        (en),
    .cmd_byte  (cmd_byte),
    .txrdy     (txrdy),
    .rxrdy     (rxrdy),
    .rx_data   (rx_data),
    .wen_n     (wen_n),
    .oen_n     (oen_n),
    .tx_data   (tx_data),
    .baud_val  (baud_val),
    .tx_en     (tx_en),
    .rx_en     (rx_en),
    .rsp_data  (rsp_data),
    .rsp_idx   (rsp_idx),
    .rsp_valid (rsp_valid),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .timeout   (timeout),
    .good_cnt  (good_cnt),
    .err_cnt   (err_cnt),
    .tmo_cnt   (tmo_cnt)
  );

  always #5 CLK = ~CLK;

  // UART TX model (10-cycle busy after each accepted write) plus output logger.
  initial begin
    txrdy = 1'b1;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      if (wen_seen) begin
        txrdy = 1'b0;
        busy  = 10;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          txrdy    = 1'b1;
          rise_cyc = cyc;
        end
      end
      wen_seen = (wen_n === 1'b0);
      if (wen_seen) begin
        if (txrdy !== 1'b1) bad_strobe++;
        if (tx_n < 8) tx_b[tx_n] = tx_data;
        tx_n++;
      end
      if (rsp_valid === 1'b1) begin
        if (rsp_n < 16) begin
          rsp_d[rsp_n] = rsp_data;
          rsp_i[rsp_n] = rsp_idx;
        end
        rsp_n++;
      end
      if (frame_done === 1'b1) begin
        done_n++;
        last_err = frame_err;
      end
      if (timeout === 1'b1) begin
        tmo_n++;
        tmo_cyc = cyc;
      end
      if (txen_prev === 1'b1 && tx_en === 1'b0) fall_cyc = cyc;
      if (txen_prev === 1'b0 && tx_en === 1'b1) txen_rise_n++;
      txen_prev = tx_en;
    end
  end

  task automatic clear_logs();
    rsp_n  = 0;
    done_n = 0;
    tmo_n  = 0;
    tx_n   = 0;
    bad_strobe = 0;
    last_err = 1'bx;
    for (int k = 0; k < 16; k++) begin
      rsp_d[k] = 'x;
      rsp_i[k] = 'x;
    end
    for (int k = 0; k < 8; k++) tx_b[k] = 'x;
  endtask

  task automatic wait_txen(input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (tx_en === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    @(posedge CLK); #1;
    rx_data = b;
    rxrdy   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (oen_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK); #1;
    rxrdy = 1'b0;
  endtask

  task automatic send_frame(input int n, output bit ok);
    bit one;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_byte(frm[i], one);
      if (!one) ok = 1'b0;
    end
  endtask

  task automatic load_std(input logic [7:0] chk);
    frm[0] = 8'hEB;
    frm[1] = 8'h90;
    for (int i = 0; i < 6; i++) frm[2 + i] = 8'(i + 1);
    frm[8] = chk;
  endtask

  task automatic test_reset();
    RESET = 1'b0; en = 1'b0; cmd_byte = 8'h00; rxrdy = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge CLK);
    checks++; if (wen_n !== 1'b1) begin errors++; $display("FAIL reset_wen_n: got %b expected 1", wen_n); end
    checks++; if (oen_n !== 1'b1) begin errors++; $display("FAIL reset_oen_n: got %b expected 1", oen_n); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
    checks++; if (rx_en !== 1'b1) begin errors++; $display("FAIL reset_rx_en: got %b expected 1", rx_en); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (baud_val !== 13'd25) begin errors++; $display("FAIL reset_baud: got %0d expected 25", baud_val); end
    checks++; if ({rsp_valid, frame_done, frame_err, timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000", {rsp_valid, frame_done, frame_err, timeout});
    end
    checks++; if ({good_cnt, err_cnt, tmo_cnt} !== 48'd0) begin
      errors++; $display("FAIL reset_stats: got %h expected 0", {good_cnt, err_cnt, tmo_cnt});
    end
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_tx_frame();
    logic [7:0] exp_b [4];
    bit ok;
    exp_b = '{8'hEB, 8'h90, 8'h10, 8'h8B};
    clear_logs();
    cmd_byte = 8'h10;
    en = 1'b1;
    wait_txen(1'b1, POLL_PERIOD + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tx_start: tx_en got %b expected 1 within period", tx_en); end
    wait_txen(1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tx_end: tx_en got %b expected 0 after frame", tx_en); end
    checks++; if (tx_n !== 4) begin errors++; $display("FAIL tx_count: got %0d expected 4", tx_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_b[i] !== exp_b[i]) begin errors++; $display("FAIL tx_byte%0d: got %h expected %h", i, tx_b[i], exp_b[i]); end
    end
    checks++; if (bad_strobe !== 0) begin errors++; $display("FAIL tx_txrdy: %0d strobes without txrdy expected 0", bad_strobe); end
    checks++; if (fall_cyc - rise_cyc !== TX_GUARD) begin
      errors++; $display("FAIL tx_guard: got %0d cycles expected %0d", fall_cyc - rise_cyc, TX_GUARD);
    end
    load_std(8'h15);
    send_frame(9, ok);
    repeat (5) @(negedge CLK);
    checks++; if (!ok) begin errors++; $display("FAIL rx_reads: some byte got no oen_n strobe expected all read"); end
    checks++; if (rsp_n !== 6) begin errors++; $display("FAIL rsp_count: got %0d expected 6", rsp_n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rsp_i[i] !== 4'(i) || rsp_d[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL rsp%0d: got idx %0d data %h expected idx %0d data %h", i, rsp_i[i], rsp_d[i], i, i + 1);
      end
    end
    checks++; if (done_n !== 1 || last_err !== 1'b0) begin
      errors++; $display("FAIL good_frame: got done %0d err %b expected done 1 err 0", done_n, last_err);
    end
  endtask

  task automatic test_bad_chk();
    bit ok;
    clear_logs();
    wait_txen(1'b1, POLL_PERIOD + 20, ok);
    wait_txen(1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bad_tx_end: tx_en got %b expected 0", tx_en); end
    load_std(8'h16);
    send_frame(9, ok);
    repeat (5) @(negedge CLK);
    checks++; if (rsp_n !== 6) begin errors++; $display("FAIL bad_rsp_count: got %0d expected 6", rsp_n); end
    checks++; if (done_n !== 1 || last_err !== 1'b1) begin
      errors++; $display("FAIL bad_frame: got done %0d err %b expected done 1 err 1", done_n, last_err);
    end
  endtask

  task automatic test_stray();
    bit ok;
    clear_logs();
    frm[0] = 8'hEB; frm[1] = 8'h90; frm[2] = 8'h01;
    send_frame(3, ok);
    repeat (5) @(negedge CLK);
    checks++; if (!ok) begin errors++; $display("FAIL stray_read: idle bytes not all read expected all read"); end
    checks++; if (rsp_n !== 0 || done_n !== 0) begin
      errors++; $display("FAIL stray_ignored: got rsp %0d done %0d expected 0 0", rsp_n, done_n);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    wait_txen(1'b1, POLL_PERIOD + 20, ok);
    wait_txen(1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_tx_end: tx_en got %b expected 0", tx_en); end
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      @(negedge CLK);
      if (tmo_n != 0) break;
    end
    checks++; if (tmo_n !== 1) begin errors++; $display("FAIL tmo_pulse: got %0d pulses expected 1", tmo_n); end
    checks++; if (tmo_cyc - fall_cyc !== TIMEOUT) begin
      errors++; $display("FAIL tmo_latency: got %0d cycles expected %0d", tmo_cyc - fall_cyc, TIMEOUT);
    end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL tmo_no_done: got %0d expected 0", done_n); end
    wait_txen(1'b1, POLL_PERIOD, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_next_tx: tx_en got %b expected 1 on next tick", tx_en); end
  endtask

  task automatic test_resync();
    bit ok;
    en = 1'b0;
    clear_logs();
    wait_txen(1'b0, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sync_tx_end: tx_en got %b expected 0", tx_en); end
    frm[0] = 8'h55; frm[1] = 8'hEB; frm[2] = 8'hEB; frm[3] = 8'h90;
    for (int i = 0; i < 6; i++) frm[4 + i] = 8'(i + 1);
    frm[10] = 8'h15;
    send_frame(11, ok);
    repeat (5) @(negedge CLK);
    checks++; if (rsp_n !== 6) begin errors++; $display("FAIL sync_rsp_count: got %0d expected 6", rsp_n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rsp_i[i] !== 4'(i) || rsp_d[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL sync_rsp%0d: got idx %0d data %h expected idx %0d data %h", i, rsp_i[i], rsp_d[i], i, i + 1);
      end
    end
    checks++; if (done_n !== 1 || last_err !== 1'b0 || tmo_n !== 0) begin
      errors++; $display("FAIL sync_frame: got done %0d err %b tmo %0d expected 1 0 0", done_n, last_err, tmo_n);
    end
    txen_rise_n = 0;
    repeat (2 * POLL_PERIOD + 20) @(negedge CLK);
    checks++; if (txen_rise_n !== 0) begin errors++; $display("FAIL en_off: got %0d polls expected 0", txen_rise_n); end
`ifdef FIBGY_STATS_EN
    checks++; if (good_cnt !== 16'd2 || err_cnt !== 16'd1 || tmo_cnt !== 16'd1) begin
      errors++; $display("FAIL stats: got %0d %0d %0d expected 2 1 1", good_cnt, err_cnt, tmo_cnt);
    end
`else
    checks++; if ({good_cnt, err_cnt, tmo_cnt} !== 48'd0) begin
      errors++; $display("FAIL stats_off: got %h expected 0", {good_cnt, err_cnt, tmo_cnt});
    end
`endif
  endtask

  task automatic test_reset_mid_tx();
    bit ok;
    clear_logs();
    cmd_byte = 8'h10;
    en = 1'b1;
    wait_txen(1'b1, POLL_PERIOD + 20, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (tx_n >= 2) break;
    end
    checks++; if (tx_en !== 1'b1 || tx_n < 2) begin
      errors++; $display("FAIL mid_tx: got tx_en %b bytes %0d expected 1 and >=2", tx_en, tx_n);
    end
    RESET = 1'b0;
    #1;
    checks++; if ({wen_n, oen_n, tx_en, rx_en} !== 4'b1101) begin
      errors++; $display("FAIL async_reset: got wen/oen/tx_en/rx_en %b expected 1101", {wen_n, oen_n, tx_en, rx_en});
    end
    checks++; if (baud_val !== 13'd25 || tx_data !== 8'h00) begin
      errors++; $display("FAIL async_reset_data: got baud %0d tx_data %h expected 25 00", baud_val, tx_data);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    clear_logs();
    repeat (6) @(negedge CLK);
    checks++; if (rsp_n !== 0 || done_n !== 0 || tmo_n !== 0 || tx_en !== 1'b0) begin
      errors++; $display("FAIL post_reset: got rsp %0d done %0d tmo %0d tx_en %b expected 0 0 0 0", rsp_n, done_n, tmo_n, tx_en);
    end
    checks++; if ({good_cnt, err_cnt, tmo_cnt} !== 48'd0) begin
      errors++; $display("FAIL post_reset_stats: got %h expected 0", {good_cnt, err_cnt, tmo_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_bad_chk();
    test_stray();
    test_timeout();
    test_resync();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
